// File: rtl/udp_rx_frame_buffer.sv
// Two-bank ping-pong receive buffer between the UDP RX header parser and an AXI-Stream sink.
// Good frames are published whole and in commit order; bad or overflowing frames are dropped and counted.
module udp_rx_frame_buffer #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        udp_header_rx_done,
  input  logic [15:0] udp_len,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] m_frame_len,
  output logic [15:0] drop_cnt,
  output logic [1:0]  wr_state_dbg,
  output logic [1:0]  rd_state_dbg
);

  // Handshake: a beat transfers on any rising edge where valid && ready are both high; a
  // master holds data/keep/last stable while valid && !ready, and ready never waits on valid.

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_DISCARD = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_FETCH = 2'd1, RD_DATA = 2'd2} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [31:0]       mem [2*DEPTH];
  logic [1:0]        full;
  logic [1:0][15:0]  len;
  logic              wsel;
  logic              rsel;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [16:0]       need_words;
  logic [16:0]       got_words;
  logic [16:0]       rd_words;
  logic              frame_good;
  logic              commit;
  logic              rel_bank;
  logic [15:0]       drop_inc;
  logic [3:0]        tail_keep;
  logic [3:0]        rd_keep;
  logic              rd_last;

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  always_comb begin
    need_words = ({1'b0, len[wsel]} + 17'd3) >> 2;
    got_words  = 17'(wptr) + 17'd1;
    frame_good = !s_axis_tuser && (len[wsel] != 16'd0) && (got_words == need_words);
    commit     = (wr_state == WR_DATA) && s_axis_tvalid && s_axis_tlast && frame_good;
    rel_bank   = (rd_state == RD_DATA) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    drop_inc   = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
    rd_words   = ({1'b0, len[rsel]} + 17'd3) >> 2;
    last_idx   = ADDR_W'(rd_words - 17'd1);
    // In RD_DATA the word being loaded is the one after the word on the bus.
    rd_idx     = (rd_state == RD_DATA) ? rptr + 1'b1 : rptr;
    rd_last    = (rd_idx == last_idx);
    case (len[rsel][1:0])
      2'd1:    tail_keep = 4'b0001;
      2'd2:    tail_keep = 4'b0011;
      2'd3:    tail_keep = 4'b0111;
      default: tail_keep = 4'b1111;
    endcase
    rd_keep = rd_last ? tail_keep : 4'b1111;
  end

  always_ff @(posedge aclk) begin
    if ((wr_state == WR_DATA) && s_axis_tvalid) begin
      mem[{wsel, wptr}] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state      <= WR_IDLE;
      s_axis_tready <= 1'b0;
      wsel          <= 1'b0;
      wptr          <= '0;
      len           <= '0;
      drop_cnt      <= 16'd0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (udp_header_rx_done) begin
            s_axis_tready <= 1'b1;
            if (full[wsel]) begin
              wr_state <= WR_DISCARD;
            end else begin
              len[wsel] <= udp_len;
              wptr      <= '0;
              wr_state  <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (s_axis_tvalid) begin
            wptr <= wptr + 1'b1;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              wr_state      <= WR_IDLE;
              if (frame_good) wsel <= ~wsel;
              else            drop_cnt <= drop_inc;
            end else if (wptr == ADDR_W'(DEPTH - 1)) begin
              wr_state <= WR_DISCARD;
            end
          end
        end
        WR_DISCARD: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            drop_cnt      <= drop_inc;
            wr_state      <= WR_IDLE;
          end
        end
        default: begin
          s_axis_tready <= 1'b0;
          wr_state      <= WR_IDLE;
        end
      endcase
    end
  end

  // Commit and release always hit different banks, so both may land in one cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      full <= 2'b00;
    end else begin
      if (commit)   full[wsel] <= 1'b1;
      if (rel_bank) full[rsel] <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state      <= RD_IDLE;
      rsel          <= 1'b0;
      rptr          <= '0;
      m_axis_tdata  <= 32'd0;
      m_axis_tkeep  <= 4'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_frame_len   <= 16'd0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          m_frame_len <= len[rsel];
          if (full[rsel]) begin
            rptr     <= '0;
            rd_state <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          m_axis_tdata  <= mem[{rsel, rd_idx}];
          m_axis_tkeep  <= rd_keep;
          m_axis_tlast  <= rd_last;
          m_axis_tvalid <= 1'b1;
          rd_state      <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              rsel          <= ~rsel;
              rd_state      <= RD_IDLE;
            end else begin
              rptr         <= rd_idx;
              m_axis_tdata <= mem[{rsel, rd_idx}];
              m_axis_tkeep <= rd_keep;
              m_axis_tlast <= rd_last;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_buffer.sv
// Bench for udp_rx_frame_buffer: directed cases plus randomized frames scored against a
// frame-level model (expected word queue, occupancy and drop count derived from the frame rules).
module tb_udp_rx_frame_buffer;

  localparam int DEPTH = 256;

  logic        aclk = 1'b0;
  logic        areset;
  logic        udp_header_rx_done;
  logic [15:0] udp_len;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] m_frame_len;
  logic [15:0] drop_cnt;
  logic [1:0]  wr_state_dbg;
  logic [1:0]  rd_state_dbg;

  always #5 aclk = ~aclk;

  udp_rx_frame_buffer #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .udp_header_rx_done (udp_header_rx_done),
    .udp_len            (udp_len),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tlast       (s_axis_tlast),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tready      (s_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready),
    .m_frame_len        (m_frame_len),
    .drop_cnt           (drop_cnt),
    .wr_state_dbg       (wr_state_dbg),
    .rd_state_dbg       (rd_state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: {frame_len[15:0], last, keep[3:0], data[31:0]}
  logic [52:0] exp_q[$];
  int committed = 0;
  int released  = 0;
  int exp_drop  = 0;
  int ready_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [3:0] keep_of(input int l);
    case (l % 4)
      1:       return 4'b0001;
      2:       return 4'b0011;
      3:       return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Downstream ready: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: ordering, content, stability under stall, and no bubbles mid-frame.
  logic        p_stall = 1'b0;
  logic        p_flow  = 1'b0;
  logic [36:0] p_word  = '0;
  logic [52:0] e;

  always @(negedge aclk) begin
    if (areset) begin
      p_stall = 1'b0;
      p_flow  = 1'b0;
    end else begin
      if (p_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_hold", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, p_word);
      end
      if (p_flow) check("no_gap", m_axis_tvalid, 1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_axis_tvalid & m_axis_tready, 0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e[31:0]);
          check("tkeep", m_axis_tkeep, e[35:32]);
          check("tlast", m_axis_tlast, e[36]);
          check("frame_len", m_frame_len, e[52:37]);
          if (e[36]) released++;
        end
      end
      p_stall = m_axis_tvalid && !m_axis_tready;
      p_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      p_flow  = m_axis_tvalid && m_axis_tready && !m_axis_tlast;
    end
  end

  task automatic do_reset();
    areset = 1'b1;
    udp_header_rx_done = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    tick();
    @(negedge aclk);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tkeep", m_axis_tkeep, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_frame_len", m_frame_len, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_s_tready", s_axis_tready, 0);
    exp_q.delete();
    committed = 0;
    released  = 0;
    exp_drop  = 0;
    tick();
    areset = 1'b0;
  endtask

  // Drives one header plus nbeats payload beats and records the model's verdict.
  task automatic send_frame(input int len, input int nbeats, input bit err, input bit gaps);
    logic [31:0] w;
    bit good;
    int need;
    need = (len + 3) / 4;
    good = ((committed - released) < 2) && !err && (len != 0) &&
           (nbeats == need) && (nbeats <= DEPTH);
    udp_header_rx_done = 1'b1;
    udp_len = 16'(len);
    tick();
    udp_header_rx_done = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_axis_tvalid = 1'b0;
          tick();
        end
      end
      w = $urandom;
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == nbeats - 1);
      s_axis_tuser  = (i == nbeats - 1) ? err : 1'($urandom_range(0, 1));
      @(negedge aclk);
      check("s_tready", s_axis_tready, 1);
      tick();
      if (good) exp_q.push_back({16'(len), (i == need - 1), (i == need - 1) ? keep_of(len) : 4'hF, w});
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    if (good) committed++;
    else if (exp_drop != 65535) exp_drop++;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      tick();
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_drops();
    @(negedge aclk);
    check("drop_cnt", drop_cnt, exp_drop);
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t;
    int len;
    int need;
    int kind;
    int good_cnt;
    areset = 1'b1;
    udp_header_rx_done = 1'b0;
    udp_len = 16'd0;
    s_axis_tdata  = 32'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    tick();
    do_reset();

    // Three-word frame, len 10, with first-beat latency measured from the commit edge.
    ready_mode = 1;
    tick();
    send_frame(10, 3, 0, 0);
    lat = 0;
    do begin
      @(negedge aclk);
      lat++;
    end while (!m_axis_tvalid && lat < 10);
    check("first_beat_latency", lat, 3);
    tick();
    wait_drain();
    check_drops();

    // Errored tlast beat is dropped, then a single-word frame.
    send_frame(10, 3, 1, 0);
    check_drops();
    send_frame(4, 1, 0, 0);
    wait_drain();
    check_drops();

    // Both banks fill under back-pressure; the third frame is sunk and counted.
    ready_mode = 0;
    tick();
    tick();
    send_frame(8, 2, 0, 0);
    send_frame(8, 2, 0, 0);
    send_frame(8, 2, 0, 0);
    check_drops();
    @(negedge aclk);
    check("stalled_valid", m_axis_tvalid, 1);
    tick();
    ready_mode = 1;
    wait_drain();

    // Length mismatch and bank overflow.
    send_frame(16, 3, 0, 0);
    check_drops();
    send_frame(1028, 257, 0, 0);
    check_drops();
    send_frame(1024, 256, 0, 0);
    wait_drain();
    check_drops();

    // Randomized traffic with random downstream stalls and occasional bad frames.
    ready_mode = 2;
    good_cnt = 0;
    while (good_cnt < 100) begin
      t = 0;
      while ((committed - released) >= 2 && t < 5000) begin
        tick();
        t++;
      end
      if (t >= 5000) check("occupancy_wait", t, 0);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(65, 1024);
      else                           len = $urandom_range(1, 64);
      need = (len + 3) / 4;
      kind = $urandom_range(0, 7);
      if (kind == 0)      send_frame(len, need, 1, 1);
      else if (kind == 1) send_frame(len, (need > 1) ? need - 1 : need + 1, 0, 1);
      else begin
        send_frame(len, need, 0, 1);
        good_cnt++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain();
    check_drops();

    // Reset in the middle of a write: the partial frame must never surface.
    ready_mode = 1;
    udp_header_rx_done = 1'b1;
    udp_len = 16'd40;
    tick();
    udp_header_rx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata  = $urandom;
      s_axis_tvalid = 1'b1;
      tick();
    end
    do_reset();
    send_frame(20, 5, 0, 0);
    wait_drain();
    check_drops();

    // Reset while a stored frame is stalled on the output.
    ready_mode = 0;
    tick();
    send_frame(12, 3, 0, 0);
    t = 0;
    do begin
      @(negedge aclk);
      t++;
    end while (!m_axis_tvalid && t < 20);
    check("mid_read_valid", m_axis_tvalid, 1);
    tick();
    do_reset();
    ready_mode = 1;
    tick();
    send_frame(7, 2, 0, 0);
    wait_drain();
    repeat (5) tick();
    check_drops();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
